// File: rtl/ps2_controller_if.sv
// Byte handshake between the PS/2 front end and the serial-controller emulation.
// The front end (master) offers a byte with ready; the consumer acks via sending.
interface ps2_controller_if;
  logic [7:0] ps2_data;
  logic       ps2_ready;
  logic       ps2_sending;

  modport master (output ps2_data, output ps2_ready, input ps2_sending);
  modport slave  (input ps2_data, input ps2_ready, output ps2_sending);
endinterface

// File: rtl/ps2_controller.sv
// PS/2 keyboard receiver and scan-code-set-2 translator producing the Gigatron input byte.
// Pipeline: sync -> frame sample -> decode -> holding register with ready/ack handshake.
module ps2_controller (
  input  logic        clk,
  input  logic        rst,
  input  logic [2:0]  dbg_sel,
  output logic [15:0] dbg,
  input  logic        PS2_CLK,
  input  logic        PS2_DAT,
  ps2_controller_if.master host
);

  typedef enum logic [1:0] {HS_IDLE, HS_HELD, HS_SEND} hs_state_e;

  logic [1:0]  clk_sync, dat_sync;
  logic        clk_prev;
  logic        fall, dat;
  logic [3:0]  bit_cnt;
  logic [9:0]  shreg;
  logic [16:0] to_cnt;
  logic        frame_ok;
  logic        frm_vld;
  logic [7:0]  frm_code, last_code, frm_cnt, err_cnt;
  logic        brk, ext, shift;
  logic        map_hit;
  logic [15:0] map_pair;
  logic [7:0]  map_byte;
  logic        xlat_vld;
  logic [7:0]  xlat_byte;
  hs_state_e   hs_state, hs_state_n;
  logic [7:0]  data_q, data_n;

  // Sync stages reset to the idle-high line level so reset never fakes a falling edge.
  // NOTE: sequential state is assigned with <= only, so every flop sees pre-edge values.
  always_ff @(posedge clk) begin
    if (rst) begin
      clk_sync <= 2'b11;
      dat_sync <= 2'b11;
      clk_prev <= 1'b1;
    end else begin
      clk_sync <= {clk_sync[0], PS2_CLK};
      dat_sync <= {dat_sync[0], PS2_DAT};
      clk_prev <= clk_sync[1];
    end
  end

  assign fall = clk_prev & ~clk_sync[1];
  assign dat  = dat_sync[1];

  // shreg holds {parity, data[7:0], start} once ten bits are in; dat is the stop bit.
  assign frame_ok = ~shreg[0] & dat & (^shreg[9:1]);

  always_ff @(posedge clk) begin
    if (rst) begin
      bit_cnt   <= 4'd0;
      shreg     <= 10'd0;
      to_cnt    <= 17'd0;
      frm_vld   <= 1'b0;
      frm_code  <= 8'h00;
      last_code <= 8'h00;
      frm_cnt   <= 8'h00;
      err_cnt   <= 8'h00;
    end else begin
      frm_vld <= 1'b0;
      if (fall) begin
        to_cnt <= 17'd0;
        shreg  <= {dat, shreg[9:1]};
        if (bit_cnt == 4'd10) begin
          bit_cnt <= 4'd0;
          if (frame_ok) begin
            frm_vld   <= 1'b1;
            frm_code  <= shreg[8:1];
            last_code <= shreg[8:1];
            frm_cnt   <= frm_cnt + 8'd1;
          end else begin
            err_cnt <= err_cnt + 8'd1;
          end
        end else begin
          bit_cnt <= bit_cnt + 4'd1;
        end
      end else if (bit_cnt != 4'd0) begin
        if (to_cnt == '1) begin
          bit_cnt <= 4'd0;
          to_cnt  <= 17'd0;
        end else begin
          to_cnt <= to_cnt + 17'd1;
        end
      end else begin
        to_cnt <= 17'd0;
      end
    end
  end

  // map_pair = {unshifted, shifted} US-layout bytes for the current code.
  // NOTE: defaults come first so every path assigns every signal and no latch is inferred.
  always_comb begin
    map_hit  = 1'b1;
    map_pair = 16'h0000;
    if (ext) begin
      case (frm_code)
        8'h75: map_pair = 16'hF7F7;
        8'h72: map_pair = 16'hFBFB;
        8'h6B: map_pair = 16'hFDFD;
        8'h74: map_pair = 16'hFEFE;
        default: map_hit = 1'b0;
      endcase
    end else begin
      case (frm_code)
        8'h1C: map_pair = 16'h6141;  8'h32: map_pair = 16'h6242;
        8'h21: map_pair = 16'h6343;  8'h23: map_pair = 16'h6444;
        8'h24: map_pair = 16'h6545;  8'h2B: map_pair = 16'h6646;
        8'h34: map_pair = 16'h6747;  8'h33: map_pair = 16'h6848;
        8'h43: map_pair = 16'h6949;  8'h3B: map_pair = 16'h6A4A;
        8'h42: map_pair = 16'h6B4B;  8'h4B: map_pair = 16'h6C4C;
        8'h3A: map_pair = 16'h6D4D;  8'h31: map_pair = 16'h6E4E;
        8'h44: map_pair = 16'h6F4F;  8'h4D: map_pair = 16'h7050;
        8'h15: map_pair = 16'h7151;  8'h2D: map_pair = 16'h7252;
        8'h1B: map_pair = 16'h7353;  8'h2C: map_pair = 16'h7454;
        8'h3C: map_pair = 16'h7555;  8'h2A: map_pair = 16'h7656;
        8'h1D: map_pair = 16'h7757;  8'h22: map_pair = 16'h7858;
        8'h35: map_pair = 16'h7959;  8'h1A: map_pair = 16'h7A5A;
        8'h16: map_pair = 16'h3121;  8'h1E: map_pair = 16'h3240;
        8'h26: map_pair = 16'h3323;  8'h25: map_pair = 16'h3424;
        8'h2E: map_pair = 16'h3525;  8'h36: map_pair = 16'h365E;
        8'h3D: map_pair = 16'h3726;  8'h3E: map_pair = 16'h382A;
        8'h46: map_pair = 16'h3928;  8'h45: map_pair = 16'h3029;
        8'h0E: map_pair = 16'h607E;  8'h4E: map_pair = 16'h2D5F;
        8'h55: map_pair = 16'h3D2B;  8'h54: map_pair = 16'h5B7B;
        8'h5B: map_pair = 16'h5D7D;  8'h5D: map_pair = 16'h5C7C;
        8'h4C: map_pair = 16'h3B3A;  8'h52: map_pair = 16'h2722;
        8'h41: map_pair = 16'h2C3C;  8'h49: map_pair = 16'h2E3E;
        8'h4A: map_pair = 16'h2F3F;
        8'h29: map_pair = 16'h2020;  8'h5A: map_pair = 16'h0A0A;
        8'h66: map_pair = 16'h7F7F;  8'h0D: map_pair = 16'h0909;
        8'h76: map_pair = 16'h1B1B;
        default: map_hit = 1'b0;
      endcase
    end
  end

  assign map_byte = shift ? map_pair[7:0] : map_pair[15:8];

  // Prefix bytes arm brk/ext; every other code consumes them.
  always_ff @(posedge clk) begin
    if (rst) begin
      brk       <= 1'b0;
      ext       <= 1'b0;
      shift     <= 1'b0;
      xlat_vld  <= 1'b0;
      xlat_byte <= 8'hFF;
    end else begin
      xlat_vld <= 1'b0;
      if (frm_vld) begin
        if (frm_code == 8'hF0) begin
          brk <= 1'b1;
        end else if (frm_code == 8'hE0) begin
          ext <= 1'b1;
        end else begin
          brk <= 1'b0;
          ext <= 1'b0;
          if (frm_code == 8'h12 || frm_code == 8'h59) begin
            shift <= ~brk;
          end else if (!brk && map_hit) begin
            xlat_vld  <= 1'b1;
            xlat_byte <= map_byte;
          end
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      hs_state <= HS_IDLE;
      data_q   <= 8'hFF;
    end else begin
      hs_state <= hs_state_n;
      data_q   <= data_n;
    end
  end

  // A byte arriving while one is held, including on the ack-fall cycle, is dropped.
  always_comb begin
    hs_state_n = hs_state;
    data_n     = data_q;
    case (hs_state)
      HS_IDLE: if (xlat_vld) begin
        hs_state_n = HS_HELD;
        data_n     = xlat_byte;
      end
      HS_HELD: if (host.ps2_sending) hs_state_n = HS_SEND;
      HS_SEND: if (!host.ps2_sending) begin
        hs_state_n = HS_IDLE;
        data_n     = 8'hFF;
      end
      default: hs_state_n = HS_IDLE;
    endcase
  end

  assign host.ps2_data  = data_q;
  assign host.ps2_ready = (hs_state != HS_IDLE);

  always_ff @(posedge clk) begin
    if (rst) begin
      dbg <= 16'h0000;
    end else begin
      case (dbg_sel)
        3'd0:    dbg <= {last_code, data_q};
        3'd1:    dbg <= {frm_cnt, err_cnt};
        3'd2:    dbg <= {12'h000, brk, ext, shift, host.ps2_ready};
        3'd3:    dbg <= {5'h00, bit_cnt, 7'h00};
        default: dbg <= 16'h0000;
      endcase
    end
  end

endmodule

// File: tb/tb_ps2_controller.sv
// Bench for ps2_controller: drives PS/2 frames on the pins and compares the handshake
// outputs and debug views against a table-driven keyboard model.
module tb_ps2_controller;

  localparam int H = 8;  // PS/2 half bit period in clk cycles

  logic        clk = 1'b0;
  logic        rst;
  logic [2:0]  dbg_sel;
  logic [15:0] dbg;
  logic        PS2_CLK, PS2_DAT;

  ps2_controller_if host ();

  ps2_controller dut (
    .clk     (clk),
    .rst     (rst),
    .dbg_sel (dbg_sel),
    .dbg     (dbg),
    .PS2_CLK (PS2_CLK),
    .PS2_DAT (PS2_DAT),
    .host    (host)
  );

  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;

  // Keyboard model: layout tables plus prefix/shift flags and a one-byte holding slot.
  bit [7:0] lo_map[bit [7:0]];
  bit [7:0] hi_map[bit [7:0]];
  bit [7:0] arrow_map[bit [7:0]];
  bit       m_brk, m_ext, m_shift, m_ready;
  bit [7:0] m_data;
  int       m_frm, m_err;

  bit [7:0] letter_codes[$] = '{8'h1C, 8'h32, 8'h21, 8'h23, 8'h24, 8'h2B, 8'h34, 8'h33,
                                8'h43, 8'h3B, 8'h42, 8'h4B, 8'h3A, 8'h31, 8'h44, 8'h4D,
                                8'h15, 8'h2D, 8'h1B, 8'h2C, 8'h3C, 8'h2A, 8'h1D, 8'h22,
                                8'h35, 8'h1A};
  bit [7:0] sym_codes[$] = '{8'h16, 8'h1E, 8'h26, 8'h25, 8'h2E, 8'h36, 8'h3D, 8'h3E,
                             8'h46, 8'h45, 8'h0E, 8'h4E, 8'h55, 8'h54, 8'h5B, 8'h5D,
                             8'h4C, 8'h52, 8'h41, 8'h49, 8'h4A};
  bit [7:0] sym_lo[$] = '{8'h31, 8'h32, 8'h33, 8'h34, 8'h35, 8'h36, 8'h37, 8'h38,
                          8'h39, 8'h30, 8'h60, 8'h2D, 8'h3D, 8'h5B, 8'h5D, 8'h5C,
                          8'h3B, 8'h27, 8'h2C, 8'h2E, 8'h2F};
  bit [7:0] sym_hi[$] = '{8'h21, 8'h40, 8'h23, 8'h24, 8'h25, 8'h5E, 8'h26, 8'h2A,
                          8'h28, 8'h29, 8'h7E, 8'h5F, 8'h2B, 8'h7B, 8'h7D, 8'h7C,
                          8'h3A, 8'h22, 8'h3C, 8'h3E, 8'h3F};
  bit [7:0] special_codes[$] = '{8'h29, 8'h5A, 8'h66, 8'h0D, 8'h76};
  bit [7:0] special_vals[$]  = '{8'h20, 8'h0A, 8'h7F, 8'h09, 8'h1B};
  bit [7:0] arrow_codes[$]   = '{8'h75, 8'h72, 8'h6B, 8'h74};
  bit [7:0] arrow_vals[$]    = '{8'hF7, 8'hFB, 8'hFD, 8'hFE};

  task automatic build_tables();
    string letters = "abcdefghijklmnopqrstuvwxyz";
    for (int i = 0; i < 26; i++) begin
      lo_map[letter_codes[i]] = letters[i];
      hi_map[letter_codes[i]] = 8'(letters[i] - 8'h20);
    end
    for (int i = 0; i < 21; i++) begin
      lo_map[sym_codes[i]] = sym_lo[i];
      hi_map[sym_codes[i]] = sym_hi[i];
    end
    for (int i = 0; i < 5; i++) begin
      lo_map[special_codes[i]] = special_vals[i];
      hi_map[special_codes[i]] = special_vals[i];
    end
    for (int i = 0; i < 4; i++) arrow_map[arrow_codes[i]] = arrow_vals[i];
  endtask

  task automatic model_reset();
    m_brk = 0; m_ext = 0; m_shift = 0; m_ready = 0; m_data = 8'hFF;
    m_frm = 0; m_err = 0;
  endtask

  task automatic model_code(input bit [7:0] c);
    bit       hit;
    bit [7:0] val;
    m_frm++;
    if (c == 8'hF0) m_brk = 1;
    else if (c == 8'hE0) m_ext = 1;
    else begin
      if (c == 8'h12 || c == 8'h59) m_shift = !m_brk;
      else if (!m_brk) begin
        hit = 0;
        val = 8'h00;
        if (m_ext && arrow_map.exists(c)) begin hit = 1; val = arrow_map[c]; end
        else if (!m_ext && lo_map.exists(c)) begin
          hit = 1;
          val = m_shift ? hi_map[c] : lo_map[c];
        end
        if (hit && !m_ready) begin m_ready = 1; m_data = val; end
      end
      m_brk = 0;
      m_ext = 0;
    end
  endtask

  // All waits end #1 after a rising edge, away from the active edge.
  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic ps2_bit(input logic b);
    PS2_DAT = b;
    tick(H);
    PS2_CLK = 1'b0;
    tick(H);
    PS2_CLK = 1'b1;
  endtask

  function automatic logic [10:0] make_frame(input bit [7:0] code, input bit bad_par);
    return {1'b1, (~^code) ^ bad_par, code, 1'b0};
  endfunction

  task automatic send_frame(input bit [7:0] code, input bit bad_par);
    logic [10:0] f;
    f = make_frame(code, bad_par);
    for (int i = 0; i < 11; i++) ps2_bit(f[i]);
    tick(4);
    if (bad_par) m_err++;
    else model_code(code);
  endtask

  task automatic do_reset();
    rst = 1'b1;
    PS2_CLK = 1'b1;
    PS2_DAT = 1'b1;
    host.ps2_sending = 1'b0;
    tick(3);
    rst = 1'b0;
    tick(1);
    model_reset();
  endtask

  task automatic do_ack(input int len);
    host.ps2_sending = 1'b1;
    tick(len);
    host.ps2_sending = 1'b0;
    tick(1);
    if (m_ready) begin m_ready = 0; m_data = 8'hFF; end
  endtask

  task automatic read_dbg(input logic [2:0] sel);
    dbg_sel = sel;
    tick(2);
  endtask

  task automatic test_reset();
    dbg_sel = 3'd0;
    rst = 1'b1;
    PS2_CLK = 1'b1;
    PS2_DAT = 1'b1;
    host.ps2_sending = 1'b0;
    tick(3);
    total++; if (host.ps2_ready !== 1'b0) begin bad++; $display("FAIL reset_ready: got %b want 0", host.ps2_ready); end
    total++; if (host.ps2_data !== 8'hFF) begin bad++; $display("FAIL reset_data: got %h want ff", host.ps2_data); end
    total++; if (dbg !== 16'h0000) begin bad++; $display("FAIL reset_dbg: got %h want 0000", dbg); end
    rst = 1'b0;
    tick(1);
    model_reset();
    read_dbg(3'd1);
    total++; if (dbg !== 16'h0000) begin bad++; $display("FAIL reset_counters: got %h want 0000", dbg); end
  endtask

  task automatic test_basic();
    logic [10:0] f;
    do_reset();
    f = make_frame(8'h1C, 1'b0);
    for (int i = 0; i < 10; i++) ps2_bit(f[i]);
    PS2_DAT = f[10];
    tick(H);
    PS2_CLK = 1'b0;
    tick(4);
    total++; if (host.ps2_ready !== 1'b0) begin bad++; $display("FAIL basic_early_ready: got %b want 0", host.ps2_ready); end
    tick(1);
    total++; if (host.ps2_ready !== 1'b1) begin bad++; $display("FAIL basic_ready: got %b want 1", host.ps2_ready); end
    total++; if (host.ps2_data !== 8'h61) begin bad++; $display("FAIL basic_data: got %h want 61", host.ps2_data); end
    tick(H);
    PS2_CLK = 1'b1;
    model_code(8'h1C);
    read_dbg(3'd1);
    total++; if (dbg !== 16'h0100) begin bad++; $display("FAIL basic_counts: got %h want 0100", dbg); end
    read_dbg(3'd0);
    total++; if (dbg !== 16'h1C61) begin bad++; $display("FAIL basic_dbg0: got %h want 1c61", dbg); end
    do_ack(3);
  endtask

  task automatic test_shift();
    do_reset();
    send_frame(8'h12, 0);
    send_frame(8'h1C, 0);
    total++; if (host.ps2_data !== 8'h41) begin bad++; $display("FAIL shift_upper: got %h want 41", host.ps2_data); end
    send_frame(8'hF0, 0);
    send_frame(8'h1C, 0);
    send_frame(8'hF0, 0);
    send_frame(8'h12, 0);
    total++; if ({host.ps2_ready, host.ps2_data} !== 9'h141) begin bad++; $display("FAIL shift_hold: got %h want 141", {host.ps2_ready, host.ps2_data}); end
    read_dbg(3'd2);
    total++; if (dbg !== 16'h0001) begin bad++; $display("FAIL shift_flags: got %h want 0001", dbg); end
    do_ack(2);
  endtask

  task automatic test_arrow();
    do_reset();
    send_frame(8'hE0, 0);
    send_frame(8'h75, 0);
    total++; if ({host.ps2_ready, host.ps2_data} !== 9'h1F7) begin bad++; $display("FAIL arrow_up: got %h want 1f7", {host.ps2_ready, host.ps2_data}); end
    do_ack(4);
    send_frame(8'hE0, 0);
    send_frame(8'hF0, 0);
    send_frame(8'h75, 0);
    total++; if ({host.ps2_ready, host.ps2_data} !== 9'h0FF) begin bad++; $display("FAIL arrow_break: got %h want 0ff", {host.ps2_ready, host.ps2_data}); end
    read_dbg(3'd2);
    total++; if (dbg !== 16'h0000) begin bad++; $display("FAIL arrow_flags: got %h want 0000", dbg); end
  endtask

  task automatic test_bad_parity();
    do_reset();
    send_frame(8'h1C, 1);
    total++; if (host.ps2_ready !== 1'b0) begin bad++; $display("FAIL parity_ready: got %b want 0", host.ps2_ready); end
    read_dbg(3'd1);
    total++; if (dbg !== 16'h0001) begin bad++; $display("FAIL parity_counts: got %h want 0001", dbg); end
  endtask

  task automatic test_back_to_back();
    do_reset();
    send_frame(8'h1C, 0);
    send_frame(8'h32, 0);
    total++; if ({host.ps2_ready, host.ps2_data} !== 9'h161) begin bad++; $display("FAIL drop_hold: got %h want 161", {host.ps2_ready, host.ps2_data}); end
    host.ps2_sending = 1'b1;
    tick(10);
    total++; if ({host.ps2_ready, host.ps2_data} !== 9'h161) begin bad++; $display("FAIL drop_sending: got %h want 161", {host.ps2_ready, host.ps2_data}); end
    host.ps2_sending = 1'b0;
    tick(1);
    m_ready = 0;
    m_data = 8'hFF;
    total++; if ({host.ps2_ready, host.ps2_data} !== 9'h0FF) begin bad++; $display("FAIL drop_ack: got %h want 0ff", {host.ps2_ready, host.ps2_data}); end
  endtask

  task automatic test_timeout();
    logic [10:0] f;
    do_reset();
    dbg_sel = 3'd3;
    f = make_frame(8'h29, 1'b0);
    for (int i = 0; i < 5; i++) ps2_bit(f[i]);
    tick((1 << 17) - 50 - H);
    total++; if (dbg !== 16'h0280) begin bad++; $display("FAIL timeout_early: got %h want 0280", dbg); end
    tick(100);
    total++; if (dbg !== 16'h0000) begin bad++; $display("FAIL timeout_cleared: got %h want 0000", dbg); end
    send_frame(8'h29, 0);
    total++; if ({host.ps2_ready, host.ps2_data} !== 9'h120) begin bad++; $display("FAIL timeout_space: got %h want 120", {host.ps2_ready, host.ps2_data}); end
  endtask

  task automatic test_reset_mid_frame();
    logic [10:0] f;
    do_reset();
    dbg_sel = 3'd0;
    send_frame(8'h1C, 0);
    f = make_frame(8'h32, 1'b0);
    for (int i = 0; i < 4; i++) ps2_bit(f[i]);
    rst = 1'b1;
    tick(2);
    total++; if ({host.ps2_ready, host.ps2_data} !== 9'h0FF) begin bad++; $display("FAIL midrst_out: got %h want 0ff", {host.ps2_ready, host.ps2_data}); end
    total++; if (dbg !== 16'h0000) begin bad++; $display("FAIL midrst_dbg: got %h want 0000", dbg); end
    rst = 1'b0;
    model_reset();
    read_dbg(3'd3);
    total++; if (dbg !== 16'h0000) begin bad++; $display("FAIL midrst_bitcnt: got %h want 0000", dbg); end
    send_frame(8'h1C, 0);
    total++; if ({host.ps2_ready, host.ps2_data} !== 9'h161) begin bad++; $display("FAIL midrst_frame: got %h want 161", {host.ps2_ready, host.ps2_data}); end
  endtask

  task automatic test_random();
    int kind;
    do_reset();
    for (int t = 0; t < 60; t++) begin
      kind = int'($urandom_range(8));
      case (kind)
        0: send_frame(letter_codes[$urandom_range(25)], 0);
        1: begin send_frame(8'hF0, 0); send_frame(letter_codes[$urandom_range(25)], 0); end
        2: send_frame($urandom_range(1) ? 8'h12 : 8'h59, 0);
        3: begin send_frame(8'hF0, 0); send_frame($urandom_range(1) ? 8'h12 : 8'h59, 0); end
        4: begin send_frame(8'hE0, 0); send_frame(arrow_codes[$urandom_range(3)], 0); end
        5: begin
          send_frame(8'hE0, 0);
          send_frame(8'hF0, 0);
          send_frame(arrow_codes[$urandom_range(3)], 0);
        end
        6: begin
          if ($urandom_range(3) == 0) send_frame(special_codes[$urandom_range(4)], 0);
          else send_frame(sym_codes[$urandom_range(20)], 0);
        end
        7: send_frame(8'h05, 0);
        default: send_frame(letter_codes[$urandom_range(25)], 1);
      endcase
      total++;
      if ({host.ps2_ready, host.ps2_data} !== {m_ready, m_data}) begin
        bad++;
        $display("FAIL random_out[%0d]: got %h want %h", t, {host.ps2_ready, host.ps2_data}, {m_ready, m_data});
      end
      if (m_ready && $urandom_range(1) == 1) begin
        do_ack(int'($urandom_range(6, 1)));
        total++;
        if ({host.ps2_ready, host.ps2_data} !== 9'h0FF) begin
          bad++;
          $display("FAIL random_ack[%0d]: got %h want 0ff", t, {host.ps2_ready, host.ps2_data});
        end
      end
    end
    read_dbg(3'd1);
    total++;
    if (dbg !== {m_frm[7:0], m_err[7:0]}) begin
      bad++;
      $display("FAIL random_counts: got %h want %h", dbg, {m_frm[7:0], m_err[7:0]});
    end
  endtask

  initial begin
    build_tables();
    test_reset();
    test_basic();
    test_shift();
    test_arrow();
    test_bad_parity();
    test_back_to_back();
    test_reset_mid_frame();
    test_random();
    test_timeout();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
